spi_keys_frame_tx: RTL
======================

# spi_keys_frame_tx

Next-generation key-state transmitter for the keyboard FPGA. It snapshots the debounced key vector and serialises it to the MCU as a framed, integrity-checked SPI packet: a sync byte, a sequence number, the key groups and a CRC-8 trailer. It drives its own SPI clock, MOSI and chip-select, and adds ack-timeout retransmission and error reporting. It sits between the key debounce block and the MCU SPI slave.

## Interface
- NUM_KEYS, 61 — number of key inputs, 1..2040.
- CLKS_PER_HALF_BIT, 2 — system clocks per SPI half-period, ≥1.
- CPOL, 0 — SPI clock idle level. CPHA is fixed at 0.
- REFRESH_CYCLES, 3900000 — idle cycles before a forced resend; ≥2.
- ACK_TIMEOUT, 1000000 — cycles to wait for ack after chip-select rises; ≥1.
- MAX_RETRIES, 3 — number of retransmits before a frame is dropped; 0..15.
- clk_g_i  in  1  system clock; the only clock.
- rstn_g_i  in  1  asynchronous, active-low reset.
- keys_i  in  NUM_KEYS  debounced key vector, synchronous to clk_g_i.
- ack_i  in  1  MCU acknowledge level, asynchronous; synchronised internally with 2 flops.
- spi_clk_o  out  1  SPI clock.
- spi_mosi_o  out  1  serial data, MSB first.
- spi_cs_n_o  out  1  chip-select, active low, framing one packet.
- busy_o  out  1  high in every state except IDLE.
- frame_err_o  out  1  one-cycle pulse when a frame is dropped after MAX_RETRIES.
- seq_o  out  8  sequence number of the current or next frame.

## Operation
- GROUPS = ceil(NUM_KEYS/8). FRAME_BYTES = GROUPS+3.
- Frame byte order:
  - byte 0: 0xA5.
  - byte 1: seq.
  - bytes 2..GROUPS+1: keys[8g+7:8g] for g = 0.. upward. Unused pad bits in the last group are 0.
  - final byte: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over byte 1 through the last key byte.
- Snapshot register resets to all ones.
- States: IDLE, SHIFT, GAP, WAIT_ACK, WAIT_REL.
- IDLE:
  - Trigger = (keys_i != snapshot) OR (refresh counter == REFRESH_CYCLES-1) OR retry pending.
  - On a new trigger, copy keys_i to the snapshot. On a retry, keep the existing snapshot and seq.
  - Go to SHIFT.
- Refresh counter counts only in IDLE. It clears on leaving IDLE and on reaching REFRESH_CYCLES-1.
- SHIFT:
  - spi_cs_n_o is low.
  - Mode CPHA=0: MOSI is valid before the first leading edge and changes on trailing edges.
  - Bytes are sent back-to-back with no gap.
  - After the last trailing edge of the final byte, go to GAP.
- GAP: hold spi_cs_n_o low for CLKS_PER_HALF_BIT cycles, then raise it and go to WAIT_ACK.
- WAIT_ACK:
  - Synchronised ack high → WAIT_REL.
  - Timeout counter reaching ACK_TIMEOUT with retries < MAX_RETRIES → increment retries, set retry pending, go to IDLE.
  - Timeout with retries == MAX_RETRIES → pulse frame_err_o, clear retries, increment seq, go to IDLE. The snapshot counts as sent.
- WAIT_REL: synchronised ack low → increment seq, clear retries, go to IDLE.
- seq is 8 bits and wraps 255→0.
- Key changes during a frame are not sampled. They are detected in IDLE against the snapshot.
- Ack already high on entering WAIT_ACK (stale ack) is accepted as an acknowledgement.
- Reset asserted mid-frame immediately forces:
  - spi_clk_o = CPOL, spi_mosi_o = 0, spi_cs_n_o = 1;
  - busy_o = 0, frame_err_o = 0, seq_o = 0;
  - state IDLE, all counters 0.

## Timing
- Let H = CLKS_PER_HALF_BIT.
- Trigger evaluated at cycle T → spi_cs_n_o low and MOSI = bit 7 of 0xA5 at T+1.
- First leading clock edge at T+1+H.
- Each bit lasts 2H cycles; each byte 16H cycles; the frame FRAME_BYTES·16H cycles.
- spi_cs_n_o rises H cycles after the final trailing edge. busy_o stays high until the state returns to IDLE.
- Ack latency: 2 synchroniser cycles plus 1 cycle to change state.
- Timeout counter starts at 0 on the cycle spi_cs_n_o rises.
- seq_o changes on the cycle the state enters IDLE from WAIT_REL or from the drop path.
- Minimum idle between frames: 1 cycle.

## Test plan
- **Key change.** NUM_KEYS=8, H=2. Reset, keys_i=0x00, ack held 0 until WAIT_ACK, then pulsed.
  - MOSI bytes must be A5 00 00 00.
  - spi_cs_n_o low for exactly 4·32+2 cycles.
  - seq_o becomes 1 after the ack falls.
- **Second frame.** keys_i=0x00 → 0x00 held, then a refresh.
  - Frame must be A5 01 00 15 (CRC = 0x15).
  - It must start exactly REFRESH_CYCLES idle cycles after the previous return to IDLE.
- **Padding.** NUM_KEYS=10, keys_i=10'h3FF.
  - Key bytes must be FF 03.
  - FRAME_BYTES must be 5.
- **Retry and drop.** ACK_TIMEOUT=50, MAX_RETRIES=2, ack never asserted.
  - Exactly 3 identical frames with the same seq.
  - One frame_err_o pulse 50 cycles after the third spi_cs_n_o rise.
  - seq_o then increments.
- **Reset mid-frame.** Assert rstn_g_i during the 2nd byte.
  - Outputs take their reset values within the same cycle.
  - After release, a fresh frame starts with seq 0.
- **Change during frame.** Toggle keys_i during SHIFT.
  - The frame in flight is unaltered.
  - A second frame carrying the new value starts 1 cycle after returning to IDLE post-ack.

Source files
------------

// File: rtl/spi_keys_frame_tx.sv
// Snapshots the key vector and sends it to the MCU as an SPI frame: A5, seq, key bytes, CRC-8.
// Unacknowledged frames are resent; after the retries run out the frame is dropped and flagged.
module spi_keys_frame_tx #(
  parameter int NUM_KEYS          = 61,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter bit CPOL              = 1'b0,
  parameter int REFRESH_CYCLES    = 3900000,
  parameter int ACK_TIMEOUT       = 1000000,
  parameter int MAX_RETRIES       = 3
) (
  input  logic                clk_g_i,
  input  logic                rstn_g_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  input  logic                ack_i,
  output logic                spi_clk_o,
  output logic                spi_mosi_o,
  output logic                spi_cs_n_o,
  output logic                busy_o,
  output logic                frame_err_o,
  output logic [7:0]          seq_o
);

  localparam int GROUPS     = (NUM_KEYS + 7) / 8;
  localparam int PAD_BITS   = GROUPS * 8;
  localparam int DATA_BITS  = PAD_BITS + 16;
  localparam int FRAME_BITS = DATA_BITS + 8;
  localparam int HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam int IW = $clog2(FRAME_BITS);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [HW-1:0] H_LAST       = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT     = IW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] CRC_FIRST    = IW'(8);
  localparam logic [IW-1:0] CRC_BYTE     = IW'(DATA_BITS);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_CNT  = TW'(ACK_TIMEOUT);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, WAIT_ACK, WAIT_REL} state_t;

  state_t                 state, state_next;
  logic [NUM_KEYS-1:0]    snapshot;
  logic [DATA_BITS-1:0]   frame_sr;
  logic [7:0]             crc;
  logic [HW-1:0]          half_cnt;
  logic                   phase;
  logic [IW-1:0]          bit_idx;
  logic [RW-1:0]          refresh_cnt;
  logic [TW-1:0]          timeout_cnt;
  logic [3:0]             retries;
  logic                   retry_pending;
  logic [7:0]             seq;
  logic                   ack_meta, ack_sync;

  logic [PAD_BITS-1:0]    pad_keys;
  logic [PAD_BITS-1:0]    key_bytes;
  logic                   trigger, half_end, trailing, timeout, drop;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // A retry resends the stored snapshot; otherwise the live keys are framed.
  always_comb begin
    pad_keys = '0;
    pad_keys[NUM_KEYS-1:0] = retry_pending ? snapshot : keys_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < GROUPS; gi++) begin : g_key_bytes
      assign key_bytes[(GROUPS-1-gi)*8 +: 8] = pad_keys[gi*8 +: 8];
    end
  endgenerate

  assign trigger  = (keys_i != snapshot) || (refresh_cnt == REFRESH_LAST) || retry_pending;
  assign half_end = (half_cnt == H_LAST);
  assign trailing = (state == SHIFT) && half_end && phase;
  assign timeout  = (timeout_cnt == TIMEOUT_CNT);
  assign drop     = (state == WAIT_ACK) && !ack_sync && timeout && (retries >= RETRY_MAX);

  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (trigger) state_next = SHIFT;
      SHIFT:    if (trailing && (bit_idx == LAST_BIT)) state_next = GAP;
      GAP:      if (half_end) state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_sync)     state_next = WAIT_REL;
        else if (timeout) state_next = IDLE;
      end
      WAIT_REL: if (!ack_sync) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state != IDLE);
    spi_cs_n_o  = !((state == SHIFT) || (state == GAP));
    spi_clk_o   = (state == SHIFT) ? (CPOL ^ phase) : CPOL;
    spi_mosi_o  = 1'b0;
    if (state == SHIFT) begin
      spi_mosi_o = (bit_idx < CRC_BYTE) ? frame_sr[DATA_BITS-1] : crc[7];
    end
    frame_err_o = drop;
    seq_o       = seq;
  end

  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      snapshot      <= '1;
      frame_sr      <= '0;
      crc           <= '0;
      half_cnt      <= '0;
      phase         <= 1'b0;
      bit_idx       <= '0;
      refresh_cnt   <= '0;
      timeout_cnt   <= '0;
      retries       <= '0;
      retry_pending <= 1'b0;
      seq           <= '0;
      ack_meta      <= 1'b0;
      ack_sync      <= 1'b0;
    end else begin
      ack_meta    <= ack_i;
      ack_sync    <= ack_meta;
      refresh_cnt <= ((state == IDLE) && !trigger) ? refresh_cnt + RW'(1) : '0;
      timeout_cnt <= (state == WAIT_ACK) ? timeout_cnt + TW'(1) : '0;

      if ((state == SHIFT) || (state == GAP)) begin
        half_cnt <= half_end ? '0 : half_cnt + HW'(1);
      end else begin
        half_cnt <= '0;
      end

      if (state != SHIFT) begin
        phase <= 1'b0;
      end else if (half_end) begin
        phase <= ~phase;
      end

      if ((state == IDLE) && trigger) begin
        if (!retry_pending) snapshot <= keys_i;
        frame_sr      <= {8'hA5, seq, key_bytes};
        crc           <= '0;
        bit_idx       <= '0;
        retry_pending <= 1'b0;
      end

      // CRC accumulates seq and key bits as they leave, then shifts itself out.
      if (trailing) begin
        bit_idx  <= bit_idx + IW'(1);
        frame_sr <= {frame_sr[DATA_BITS-2:0], 1'b0};
        if ((bit_idx >= CRC_FIRST) && (bit_idx < CRC_BYTE)) begin
          crc <= crc_step(crc, frame_sr[DATA_BITS-1]);
        end else if (bit_idx >= CRC_BYTE) begin
          crc <= {crc[6:0], 1'b0};
        end
      end

      if ((state == WAIT_ACK) && !ack_sync && timeout) begin
        if (retries < RETRY_MAX) begin
          retries       <= retries + 4'd1;
          retry_pending <= 1'b1;
        end else begin
          retries <= '0;
          seq     <= seq + 8'd1;
        end
      end

      if ((state == WAIT_REL) && !ack_sync) begin
        retries <= '0;
        seq     <= seq + 8'd1;
      end
    end
  end

endmodule
